// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl
//   Sequencer in front of a WIDTH-bit universal shift register
//   (op 00 hold, 01 shift right, 10 shift left, 11 load).
//   It accepts one parallel word over valid/ready, issues one load, and then
//   issues WIDTH shifts in the chosen direction, one every BIT_PERIOD clocks.
//   The result is a paced parallel-to-serial transmitter. A one-cycle done
//   pulse follows the final shift.
//
// Ports
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  word handshake; in_ready is high only in IDLE
//   in_data            word to serialise
//   in_dir             0 = shift right, 1 = shift left; sampled at accept
//   fill_bit           serial fill bit; sampled at accept
//   abort              synchronous abort of the word in flight
//   op, p_in, s_in     drive the shift register
//   busy               high from the cycle after accept through DONE
//   done               one-cycle pulse after the last shift
//   bit_cnt            shifts issued for the current word
//
// All outputs are registered. Next-state outputs are derived from the next state.
module usr_shift_ctrl #(
  parameter int WIDTH      = 4,
  parameter int BIT_PERIOD = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_dir,
  input  logic                         fill_bit,
  input  logic                         abort,
  output logic [1:0]                   op,
  output logic [WIDTH-1:0]             p_in,
  output logic                         s_in,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int BW = $clog2(WIDTH+1);
  localparam int PW = $clog2(BIT_PERIOD+1);
  // The WAIT state is unreachable when BIT_PERIOD == 1. Clamp the terminal
  // count so that it stays a legal value.
  localparam int PER_MAX = (BIT_PERIOD > 1) ? BIT_PERIOD - 2 : 0;
  localparam logic [PW-1:0] PER_LAST = PW'(PER_MAX);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic [WIDTH-1:0] p_in_q, p_in_d;
  logic            s_in_q, s_in_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [PW-1:0]   per_q, per_d;
  logic [1:0]      op_q, op_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    p_in_d  = p_in_q;
    s_in_d  = s_in_q;
    bit_d   = bit_q;
    per_d   = per_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && rdy_q && !abort) begin
          state_d = ST_LOAD;
          p_in_d  = in_data;
          s_in_d  = fill_bit;
          dir_d   = in_dir;
          bit_d   = '0;
        end
      end
      ST_LOAD: begin
        per_d   = '0;
        state_d = (BIT_PERIOD > 1) ? ST_WAIT : ST_SHIFT;
      end
      ST_WAIT: begin
        if (per_q == PER_LAST) state_d = ST_SHIFT;
        else                   per_d   = per_q + PW'(1);
      end
      ST_SHIFT: begin
        // The register performs this shift on the closing edge, so it is
        // counted even if an abort arrives in the same cycle.
        bit_d = bit_q + BW'(1);
        per_d = '0;
        if (bit_q == BIT_LAST) state_d = ST_DONE;
        else                   state_d = (BIT_PERIOD > 1) ? ST_WAIT : ST_SHIFT;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;

    case (state_d)
      ST_LOAD:  op_d = OP_LOAD;
      ST_SHIFT: op_d = dir_d ? OP_SHL : OP_SHR;
      default:  op_d = OP_HOLD;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    rdy_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      p_in_q  <= '0;
      s_in_q  <= 1'b0;
      bit_q   <= '0;
      per_q   <= '0;
      op_q    <= OP_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      p_in_q  <= p_in_d;
      s_in_q  <= s_in_d;
      bit_q   <= bit_d;
      per_q   <= per_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready = rdy_q;
  assign op       = op_q;
  assign p_in     = p_in_q;
  assign s_in     = s_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bit_cnt  = bit_q;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Bench for usr_shift_ctrl. Two instances, one with BIT_PERIOD=3 and one with
// BIT_PERIOD=1, share the same stimulus. Each instance has its own
// position-in-word reference model. A shift-register emulation is driven by
// each DUT's op/p_in/s_in and compared with the model's register.
module tb_usr_shift_ctrl;
  localparam int W  = 4;
  localparam int BW = $clog2(W+1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_dir = 1'b0, fill_bit = 1'b0, abort = 1'b0;
  logic [W-1:0] in_data = '0;

  logic          in_ready_w [2];
  logic          busy_w     [2];
  logic          done_w     [2];
  logic          s_in_w     [2];
  logic [1:0]    op_w       [2];
  logic [W-1:0]  p_in_w     [2];
  logic [BW-1:0] bit_cnt_w  [2];

  always #5 clk = ~clk;

  usr_shift_ctrl #(.WIDTH(W), .BIT_PERIOD(3)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_data(in_data), .in_dir(in_dir), .fill_bit(fill_bit), .abort(abort),
    .op(op_w[0]), .p_in(p_in_w[0]), .s_in(s_in_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .bit_cnt(bit_cnt_w[0]));

  usr_shift_ctrl #(.WIDTH(W), .BIT_PERIOD(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_data(in_data), .in_dir(in_dir), .fill_bit(fill_bit), .abort(abort),
    .op(op_w[1]), .p_in(p_in_w[1]), .s_in(s_in_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .bit_cnt(bit_cnt_w[1]));

  int total = 0;
  int bad   = 0;

  // model: pos = index into the word's op sequence (-1 = idle)
  int           pos   [2];
  int           bits  [2];
  bit           rdy   [2];
  bit           m_dir [2];
  bit           m_sin [2];
  logic [W-1:0] m_pin [2];
  logic [W-1:0] m_sr  [2];
  logic [W-1:0] d_sr  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic logic [W-1:0] sr_apply(input logic [W-1:0] sr, input logic [1:0] o,
                                            input logic [W-1:0] p, input logic s);
    case (o)
      2'd1:    return {s, sr[W-1:1]};
      2'd2:    return {sr[W-2:0], s};
      2'd3:    return p;
      default: return sr;
    endcase
  endfunction

  // A word is: load, then W groups of (P-1 holds + 1 shift), then the done cycle.
  function automatic logic [1:0] exp_op(input int k);
    int p;
    p = per_of(k);
    if (pos[k] < 0)            return 2'd0;
    if (pos[k] == 0)           return 2'd3;
    if (pos[k] == 1 + W*p)     return 2'd0;
    if ((pos[k]-1) % p == p-1) return m_dir[k] ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k] = -1; bits[k] = 0; rdy[k] = 1'b0;
      m_dir[k] = 1'b0; m_sin[k] = 1'b0; m_pin[k] = '0;
    end
  endtask

  task automatic model_edge(input int k);
    int p;
    logic [1:0] o;
    p = per_of(k);
    o = exp_op(k);
    if (pos[k] >= 0) begin
      m_sr[k] = sr_apply(m_sr[k], o, m_pin[k], m_sin[k]);
      if (o == 2'd1 || o == 2'd2) bits[k]++;
      if (abort || pos[k] == 1 + W*p) begin pos[k] = -1; rdy[k] = 1'b1; end
      else pos[k]++;
    end else if (rdy[k] && in_valid && !abort) begin
      pos[k] = 0; bits[k] = 0; rdy[k] = 1'b0;
      m_pin[k] = in_data; m_sin[k] = fill_bit; m_dir[k] = in_dir;
    end else begin
      rdy[k] = 1'b1;
    end
  endtask

  task automatic check_all();
    int p;
    for (int k = 0; k < 2; k++) begin
      p = per_of(k);
      chk($sformatf("op[%0d]", k),    op_w[k],       exp_op(k));
      chk($sformatf("busy[%0d]", k),  busy_w[k],     pos[k] >= 0);
      chk($sformatf("done[%0d]", k),  done_w[k],     pos[k] == 1 + W*p);
      chk($sformatf("rdy[%0d]", k),   in_ready_w[k], (pos[k] < 0) && rdy[k]);
      chk($sformatf("bcnt[%0d]", k),  bit_cnt_w[k],  bits[k]);
      chk($sformatf("p_in[%0d]", k),  p_in_w[k],     m_pin[k]);
      chk($sformatf("s_in[%0d]", k),  s_in_w[k],     m_sin[k]);
      chk($sformatf("sr[%0d]", k),    d_sr[k],       m_sr[k]);
    end
  endtask

  // One clock: the emulated register takes the DUT's current op, the model
  // advances, then outputs are checked just after the edge.
  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      d_sr[k] = sr_apply(d_sr[k], op_w[k], p_in_w[k], s_in_w[k]);
      if (reset_n) model_edge(k);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset pulse between edges. The outputs must clear at once.
  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    #3 reset_n = 1'b1;
    cycle();
  endtask

  task automatic latency_run(input int n, output int lat0, output int lat1,
                             input bit chk_tbl);
    logic [W-1:0] tbl [4];
    tbl[0] = 4'b0101; tbl[1] = 4'b1011; tbl[2] = 4'b0111; tbl[3] = 4'b1111;
    lat0 = -1; lat1 = -1;
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (done_w[0] && lat0 < 0) lat0 = i;
      if (done_w[1] && lat1 < 0) lat1 = i;
      if (chk_tbl && i >= 2 && i <= 5) chk("sr_seq1", d_sr[1], tbl[i-2]);
    end
  endtask

  initial begin
    int l0, l1;
    model_reset();
    for (int k = 0; k < 2; k++) begin m_sr[k] = '0; d_sr[k] = '0; end
    #2 check_all();
    #10 reset_n = 1'b1;

    // 1: first word after reset, shift right with fill 0
    in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b0; fill_bit = 1'b0;
    cycle();
    chk("rdy_after_rst", in_ready_w[0], 1'b1);
    cycle();
    chk("accept1", busy_w[0], 1'b1);
    in_valid = 1'b0;
    latency_run(20, l0, l1, 1'b0);
    chk("lat_p3", l0, 13);
    chk("sr_end0", d_sr[0], 4'b0000);

    // 2: shift left with fill 1; check the P=1 register sequence
    in_valid = 1'b1; in_data = 4'b0010; in_dir = 1'b1; fill_bit = 1'b1;
    cycle();
    in_valid = 1'b0;
    latency_run(20, l0, l1, 1'b1);
    chk("lat_p1", l1, 5);

    // 3: abort during the second WAIT of the P=3 instance
    in_valid = 1'b1; in_data = 4'b0110; in_dir = 1'b0; fill_bit = 1'b1;
    cycle();
    in_valid = 1'b0;
    run(4);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_rdy", in_ready_w[0], 1'b1);
    in_valid = 1'b1; in_data = 4'b1001;
    cycle();
    chk("reaccept", busy_w[0], 1'b1);
    in_valid = 1'b0;
    run(20);

    // 4: in_valid held across several words
    in_valid = 1'b1; in_data = 4'b1100; in_dir = 1'b1; fill_bit = 1'b0;
    run(40);
    in_valid = 1'b0;
    run(20);

    // 5: reset during SHIFT
    in_valid = 1'b1; in_data = 4'b0111; in_dir = 1'b0;
    cycle();
    in_valid = 1'b0;
    run(3);
    chk("pre_rst_shift", op_w[0], 2'd1);
    reset_pulse();
    chk("rst_rdy", in_ready_w[0], 1'b1);
    run(2);

    // 6: abort together with in_valid in IDLE
    abort = 1'b1; in_valid = 1'b1;
    cycle();
    chk("abort_idle", busy_w[0], 1'b0);
    abort = 1'b0;
    cycle();
    chk("accept_after", busy_w[0], 1'b1);
    in_valid = 1'b0;
    run(20);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      abort    = ($urandom_range(0, 29) == 0);
      in_data  = W'($urandom);
      in_dir   = 1'($urandom_range(0, 1));
      fill_bit = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
